// File: rtl/add_sub_pipe_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pipe_pkg
//   Shared definitions for the pipelined adder/subtractor:
//     MODE_ADD / MODE_SUB : values of the 'mode' input
//     chunk_w()           : bits handled by each pipeline stage
//     cfg_ok()            : parameter legality check, evaluated at elaboration
// -----------------------------------------------------------------------------
package add_sub_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of one carry-chained slice.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // The datapath is split into equal slices, so WIDTH must divide evenly.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_sub_pipe_chunk.sv
// -----------------------------------------------------------------------------
// add_sub_pipe_chunk
//   One registered CHUNK-bit slice of the carry-chained adder. Adds its operand
//   slice plus the incoming carry and registers the slice sum, the carry out of
//   the slice, the carry into the slice MSB (only meaningful for the top slice,
//   where it forms the signed-overflow flag) and the beat valid bit.
//
//   Ports
//     clk, rst_n   clock, synchronous active-low reset
//     adv_i        pipeline advance enable; all registers hold when low
//     valid_i      beat valid entering this slice
//     a_i, b_i     operand slices (b_i is already inverted for subtraction)
//     carry_i      carry from the previous slice (or cin for slice 0)
//     sum_o        registered slice sum
//     carry_o      registered carry out of the slice MSB
//     carry_msb_o  registered carry into the slice MSB
//     valid_o      registered beat valid
// -----------------------------------------------------------------------------
module add_sub_pipe_chunk #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o,
  output logic             carry_msb_o,
  output logic             valid_o
);

  logic [CHUNK:0]   full_d;
  logic             carry_msb_d;

  logic [CHUNK-1:0] sum_q;
  logic             carry_q;
  logic             carry_msb_q;
  logic             valid_q;

  assign full_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};

  // The carry into a bit position is recovered from the sum bit and the two
  // operand bits, which avoids building a separate CHUNK-1 bit adder.
  assign carry_msb_d = full_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every stage samples the
    // values its neighbours held before the edge, independent of block order.
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_msb_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (adv_i) begin
      sum_q       <= full_d[CHUNK-1:0];
      carry_q     <= full_d[CHUNK];
      carry_msb_q <= carry_msb_d;
      valid_q     <= valid_i;
    end
  end

  assign sum_o       = sum_q;
  assign carry_o     = carry_q;
  assign carry_msb_o = carry_msb_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/add_sub_pipe.sv
// -----------------------------------------------------------------------------
// add_sub_pipe
//   Pipelined WIDTH-bit adder/subtractor with valid/ready handshake. The
//   operation is split into STAGES carry-chained slices of CHUNK bits; slice k
//   is computed in pipeline stage k. Upper operand slices are delayed (skew) so
//   they meet their carry, and lower result slices are delayed (deskew) so all
//   bits of one beat leave together. Latency is STAGES cycles, throughput one
//   beat per cycle; a stalled output freezes the whole pipeline.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid / in_ready   input handshake (in_ready is combinational)
//     a, b, cin, mode       operands; mode 0 = a+b+cin, 1 = a+~b+cin
//     out_valid / out_ready output handshake
//     sum, cout, ovf        result, carry out of MSB, signed overflow
//
//   Build option
//     ADD_SUB_PIPE_SAT_EN   when defined, sum clamps to the signed max/min on
//                           overflow; cout and ovf remain unsaturated.
// -----------------------------------------------------------------------------
module add_sub_pipe
  import add_sub_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("add_sub_pipe: need WIDTH >= 1, STAGES >= 1 and WIDTH divisible by STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [CHUNK-1:0] a_stg   [STAGES];
  logic [CHUNK-1:0] b_stg   [STAGES];
  logic [CHUNK-1:0] sum_stg [STAGES];
  logic [CHUNK-1:0] sum_al  [STAGES];
  logic [STAGES:0]  carry_c;
  logic [STAGES:0]  valid_c;
  logic             carry_msb_top;
  logic [WIDTH-1:0] sum_raw;

  // Global stall: the pipeline moves whenever the output slot is empty or is
  // being drained this cycle, which lets accept and drain overlap at full rate.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign b_eff = (mode == MODE_SUB) ? ~b : b;

  assign carry_c[0] = cin;
  assign valid_c[0] = in_valid;
  assign a_stg[0]   = a[CHUNK-1:0];
  assign b_stg[0]   = b_eff[CHUNK-1:0];

  // ---------------------------------------------------------------------------
  // Operand skew: slice k waits k cycles so it reaches stage k together with
  // the carry produced by stage k-1 for the same beat.
  // ---------------------------------------------------------------------------
  for (genvar k = 1; k < STAGES; k++) begin : g_skew
    logic [2*CHUNK-1:0] line_q [k];

    // NOTE: the skew lines carry operand data only; the valid bits travelling
    // alongside qualify them, so these registers are intentionally not reset.
    always_ff @(posedge clk) begin
      if (adv) begin
        line_q[0] <= {a[k*CHUNK +: CHUNK], b_eff[k*CHUNK +: CHUNK]};
        for (int i = 1; i < k; i++) begin
          line_q[i] <= line_q[i-1];
        end
      end
    end

    assign {a_stg[k], b_stg[k]} = line_q[k-1];
  end

  // ---------------------------------------------------------------------------
  // Carry-chained slices. Only the top slice's MSB carry-in is used (for ovf).
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_top
      add_sub_pipe_chunk #(
        .CHUNK(CHUNK)
      ) u_chunk (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (adv),
        .valid_i    (valid_c[k]),
        .a_i        (a_stg[k]),
        .b_i        (b_stg[k]),
        .carry_i    (carry_c[k]),
        .sum_o      (sum_stg[k]),
        .carry_o    (carry_c[k+1]),
        .carry_msb_o(carry_msb_top),
        .valid_o    (valid_c[k+1])
      );
    end else begin : g_low
      logic unused_carry_msb;

      add_sub_pipe_chunk #(
        .CHUNK(CHUNK)
      ) u_chunk (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (adv),
        .valid_i    (valid_c[k]),
        .a_i        (a_stg[k]),
        .b_i        (b_stg[k]),
        .carry_i    (carry_c[k]),
        .sum_o      (sum_stg[k]),
        .carry_o    (carry_c[k+1]),
        .carry_msb_o(unused_carry_msb),
        .valid_o    (valid_c[k+1])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Result deskew: slice j is ready after j+1 cycles and is held for
  // STAGES-1-j more so the whole word appears at the output together. These
  // registers feed sum directly, so they are reset to give sum = 0.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < STAGES; j++) begin : g_deskew
    localparam int DEPTH = STAGES - 1 - j;

    if (DEPTH == 0) begin : g_pass
      assign sum_al[j] = sum_stg[j];
    end else begin : g_dly
      logic [CHUNK-1:0] dly_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            dly_q[i] <= '0;
          end
        end else if (adv) begin
          dly_q[0] <= sum_stg[j];
          for (int i = 1; i < DEPTH; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign sum_al[j] = dly_q[DEPTH-1];
    end

    assign sum_raw[j*CHUNK +: CHUNK] = sum_al[j];
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  assign out_valid = valid_c[STAGES];
  assign cout      = carry_c[STAGES];
  assign ovf       = carry_c[STAGES] ^ carry_msb_top;

`ifdef ADD_SUB_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  // On overflow the wrapped sign is the opposite of the operands' common sign:
  // a negative-looking wrapped result means both operands were positive.
  assign sum = ovf ? (sum_raw[WIDTH-1] ? SMAX : SMIN) : sum_raw;
`else
  assign sum = sum_raw;
`endif

endmodule
